sd_ext_wbm: RTL and testbench



---
 rtl/sd_ext_wbm.sv | 204 ++++++++++++++++++++
 tb/tb_sd_ext_wbm.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_ext_wbm.sv
// Moves one 512-byte sector per request between system memory (Wishbone classic master)
// and the SD manager's sector BRAMs. Define SD_EXT_WBM_BSWAP_EN for big-endian memory.
module sd_ext_wbm #(
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        ext_read_act,
    input  logic [31:0] ext_read_addr,
    input  logic        ext_read_stop,
    output logic        ext_read_go,
    input  logic        ext_write_act,
    input  logic [31:0] ext_write_addr,
    output logic        ext_write_done,
    output logic [6:0]  bram_rd_ext_addr,
    output logic        bram_rd_ext_wren,
    output logic [31:0] bram_rd_ext_data,
    output logic [6:0]  bram_wr_ext_addr,
    input  logic [31:0] bram_wr_ext_q,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        xfer_err
);

    typedef enum logic [2:0] {
        IDLE, RD_BUS, RD_WR, RD_GO, RD_DONE, WR_FETCH, WR_BUS, WR_DONE
    } state_t;

    state_t      state, state_n;
    logic [6:0]  word, word_n;
    logic [22:0] sector, sector_n;
    logic [31:0] adr_n, dat_o_n, rd_data_n;
    logic [6:0]  rd_addr_n;
    logic [3:0]  sel_n;
    logic        cyc_n, stb_n, we_n, wren_n, go_n, done_n, err_n;
    logic        beat_end;
    logic        unused_sector_bits;

    assign unused_sector_bits = ^{ext_read_addr[31:23], ext_write_addr[31:23]};

    function automatic logic [31:0] swap(input logic [31:0] d);
`ifdef SD_EXT_WBM_BSWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    function automatic logic [31:0] beat_adr(input logic [22:0] sec, input logic [6:0] w);
        return BASE_ADDR + {sec, 9'd0} + {23'd0, w, 2'd0};
    endfunction

    // During a write beat the BRAM already sees the next word, so its q is ready in WR_FETCH.
    // The counter wraps to 0 after word 127, which makes IDLE present word 0 as well.
    assign bram_wr_ext_addr = (state == WR_BUS) ? word + 7'd1 : word;

    always_comb begin
        state_n   = state;
        word_n    = word;
        sector_n  = sector;
        adr_n     = wbm_adr_o;
        dat_o_n   = wbm_dat_o;
        sel_n     = wbm_sel_o;
        we_n      = wbm_we_o;
        cyc_n     = wbm_cyc_o;
        stb_n     = wbm_stb_o;
        wren_n    = 1'b0;
        rd_addr_n = bram_rd_ext_addr;
        rd_data_n = bram_rd_ext_data;
        go_n      = ext_read_go;
        done_n    = ext_write_done;
        err_n     = xfer_err;
        beat_end  = wbm_ack_i | wbm_err_i;

        case (state)
            IDLE: begin
                if (ext_read_act && !ext_read_go && !ext_read_stop) begin
                    state_n  = RD_BUS;
                    sector_n = ext_read_addr[22:0];
                    word_n   = '0;
                    err_n    = 1'b0;
                    cyc_n    = 1'b1;
                    stb_n    = 1'b1;
                    we_n     = 1'b0;
                    sel_n    = 4'hF;
                    adr_n    = beat_adr(ext_read_addr[22:0], 7'd0);
                end else if (ext_write_act && !ext_write_done) begin
                    state_n  = WR_FETCH;
                    sector_n = ext_write_addr[22:0];
                    word_n   = '0;
                    err_n    = 1'b0;
                end
            end
            RD_BUS: begin
                if (beat_end) begin
                    stb_n     = 1'b0;
                    rd_data_n = swap(wbm_dat_i);
                    rd_addr_n = word;
                    wren_n    = 1'b1;
                    err_n     = xfer_err | wbm_err_i;
                    state_n   = RD_WR;
                end
            end
            RD_WR: begin
                word_n = word + 7'd1;
                if (word == 7'd127) begin
                    cyc_n   = 1'b0;
                    sel_n   = '0;
                    go_n    = 1'b1;
                    state_n = RD_GO;
                end else begin
                    stb_n   = 1'b1;
                    adr_n   = beat_adr(sector, word + 7'd1);
                    state_n = RD_BUS;
                end
            end
            RD_GO: begin
                if (ext_read_stop) begin
                    go_n    = 1'b0;
                    state_n = RD_DONE;
                end
            end
            RD_DONE: begin
                if (!ext_read_stop && !ext_read_act) state_n = IDLE;
            end
            WR_FETCH: begin
                dat_o_n = swap(bram_wr_ext_q);
                cyc_n   = 1'b1;
                stb_n   = 1'b1;
                we_n    = 1'b1;
                sel_n   = 4'hF;
                adr_n   = beat_adr(sector, word);
                state_n = WR_BUS;
            end
            WR_BUS: begin
                if (beat_end) begin
                    stb_n  = 1'b0;
                    err_n  = xfer_err | wbm_err_i;
                    word_n = word + 7'd1;
                    if (word == 7'd127) begin
                        cyc_n   = 1'b0;
                        we_n    = 1'b0;
                        sel_n   = '0;
                        done_n  = 1'b1;
                        state_n = WR_DONE;
                    end else begin
                        state_n = WR_FETCH;
                    end
                end
            end
            WR_DONE: begin
                if (!ext_write_act) begin
                    done_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            word             <= '0;
            sector           <= '0;
            wbm_adr_o        <= '0;
            wbm_dat_o        <= '0;
            wbm_sel_o        <= '0;
            wbm_we_o         <= 1'b0;
            wbm_cyc_o        <= 1'b0;
            wbm_stb_o        <= 1'b0;
            bram_rd_ext_wren <= 1'b0;
            bram_rd_ext_addr <= '0;
            bram_rd_ext_data <= '0;
            ext_read_go      <= 1'b0;
            ext_write_done   <= 1'b0;
            xfer_err         <= 1'b0;
        end else begin
            state            <= state_n;
            word             <= word_n;
            sector           <= sector_n;
            wbm_adr_o        <= adr_n;
            wbm_dat_o        <= dat_o_n;
            wbm_sel_o        <= sel_n;
            wbm_we_o         <= we_n;
            wbm_cyc_o        <= cyc_n;
            wbm_stb_o        <= stb_n;
            bram_rd_ext_wren <= wren_n;
            bram_rd_ext_addr <= rd_addr_n;
            bram_rd_ext_data <= rd_data_n;
            ext_read_go      <= go_n;
            ext_write_done   <= done_n;
            xfer_err         <= err_n;
        end
    end

endmodule

// File: tb/tb_sd_ext_wbm.sv
// Directed bench for sd_ext_wbm: sector transfer table plus hand-written arbitration and reset sequences.
module tb_sd_ext_wbm;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk_50 = 1'b0;
    logic        reset_n = 1'b0;
    logic        ext_read_act = 1'b0, ext_read_stop = 1'b0, ext_write_act = 1'b0;
    logic [31:0] ext_read_addr = '0, ext_write_addr = '0;
    logic        ext_read_go, ext_write_done;
    logic [6:0]  bram_rd_ext_addr, bram_wr_ext_addr;
    logic        bram_rd_ext_wren;
    logic [31:0] bram_rd_ext_data;
    logic [31:0] bram_wr_ext_q = '0;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0;
    logic        xfer_err;

    always #5 clk_50 = ~clk_50;

    sd_ext_wbm #(.BASE_ADDR(BASE)) dut (
        .clk_50(clk_50), .reset_n(reset_n),
        .ext_read_act(ext_read_act), .ext_read_addr(ext_read_addr),
        .ext_read_stop(ext_read_stop), .ext_read_go(ext_read_go),
        .ext_write_act(ext_write_act), .ext_write_addr(ext_write_addr),
        .ext_write_done(ext_write_done),
        .bram_rd_ext_addr(bram_rd_ext_addr), .bram_rd_ext_wren(bram_rd_ext_wren),
        .bram_rd_ext_data(bram_rd_ext_data),
        .bram_wr_ext_addr(bram_wr_ext_addr), .bram_wr_ext_q(bram_wr_ext_q),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .xfer_err(xfer_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] sw(input logic [31:0] d);
`ifdef SD_EXT_WBM_BSWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    // Slave / BRAM model state
    int unsigned wait_cfg = 0;
    int          err_beat = -1;
    logic [31:0] rd_pat = '0;
    int          beat_cnt = 0;
    int          hold_viol = 0;
    int          wren_cnt = 0;
    int unsigned scnt = 0;
    logic [31:0] a0, d0;
    logic        w0;
    logic [6:0]  wr_addr_prev = '0;
    logic [31:0] adr_log [128];
    logic [31:0] wdat_log[128];
    logic        we_log  [128];
    logic [3:0]  sel_log [128];
    logic [31:0] rbram   [128];
    logic [31:0] wbram   [128];

    // Registered Wishbone slave (ack one cycle after stb plus wait_cfg) and both BRAMs, all on negedge.
    initial begin
        forever begin
            @(negedge clk_50);
            bram_wr_ext_q = wbram[wr_addr_prev];
            wr_addr_prev  = bram_wr_ext_addr;
            if (bram_rd_ext_wren) begin
                rbram[bram_rd_ext_addr] = bram_rd_ext_data;
                wren_cnt++;
            end
            if (!reset_n) begin
                wbm_ack_i = 1'b0; wbm_err_i = 1'b0; scnt = 0;
            end else if (wbm_ack_i || wbm_err_i) begin
                wbm_ack_i = 1'b0; wbm_err_i = 1'b0; scnt = 0;
                if (wbm_stb_o) hold_viol++;
            end else if (wbm_stb_o) begin
                if (scnt == 0) begin
                    a0 = wbm_adr_o; w0 = wbm_we_o; d0 = wbm_dat_o;
                end else if (wbm_adr_o !== a0 || wbm_we_o !== w0 || wbm_dat_o !== d0 || !wbm_cyc_o) begin
                    hold_viol++;
                end
                if (scnt == wait_cfg + 1) begin
                    if (beat_cnt < 128) begin
                        adr_log[beat_cnt]  = wbm_adr_o;
                        wdat_log[beat_cnt] = wbm_dat_o;
                        we_log[beat_cnt]   = wbm_we_o;
                        sel_log[beat_cnt]  = wbm_sel_o;
                    end
                    if (beat_cnt == err_beat) begin
                        wbm_err_i = 1'b1;
                        wbm_dat_i = 32'hEEEE_0000 + 32'(beat_cnt);
                    end else begin
                        wbm_ack_i = 1'b1;
                        wbm_dat_i = rd_pat + {25'd0, wbm_adr_o[8:2]};
                    end
                    beat_cnt++;
                    scnt = 0;
                end else begin
                    scnt++;
                end
            end else if (scnt != 0) begin
                hold_viol++;
                scnt = 0;
            end
        end
    end

    typedef struct {
        logic        is_wr;
        logic [31:0] sector;
        int unsigned waits;
        int          err_beat;
        logic [31:0] pat;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        int          exp_lat;
        logic        exp_err;
    } vec_t;

    task automatic do_xfer(input vec_t v);
        int lat;
        int bad_adr, bad_sel, bad_we, bad_dat;
        logic [31:0] exp_d;
        wait_cfg = v.waits; err_beat = v.err_beat; rd_pat = v.pat;
        beat_cnt = 0; hold_viol = 0; wren_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            rbram[i] = '0;
            wbram[i] = v.pat + 32'(i);
            adr_log[i] = 'x;
        end
        if (v.is_wr) begin
            ext_write_addr = v.sector; ext_write_act = 1'b1;
        end else begin
            ext_read_addr = v.sector; ext_read_act = 1'b1;
        end
        lat = 0;
        do begin
            @(negedge clk_50);
            lat++;
        end while (!(v.is_wr ? ext_write_done : ext_read_go) && lat < 3000);
        chk("latency", 32'(lat), 32'(v.exp_lat));
        chk("beats", 32'(beat_cnt), 32'd128);
        chk("first_adr", adr_log[0], v.exp_first);
        chk("last_adr", adr_log[127], v.exp_last);
        bad_adr = 0; bad_sel = 0; bad_we = 0; bad_dat = 0;
        for (int i = 0; i < 128; i++) begin
            if (adr_log[i] !== v.exp_first + 32'(i * 4)) bad_adr++;
            if (sel_log[i] !== 4'hF) bad_sel++;
            if (we_log[i] !== v.is_wr) bad_we++;
            if (v.is_wr) begin
                if (wdat_log[i] !== sw(v.pat + 32'(i))) bad_dat++;
            end else begin
                exp_d = (i == v.err_beat) ? 32'hEEEE_0000 + 32'(i) : v.pat + 32'(i);
                if (rbram[i] !== sw(exp_d)) bad_dat++;
            end
        end
        chk("adr_seq_errs", 32'(bad_adr), 32'd0);
        chk("sel_errs", 32'(bad_sel), 32'd0);
        chk("we_errs", 32'(bad_we), 32'd0);
        chk("data_errs", 32'(bad_dat), 32'd0);
        chk("wren_pulses", 32'(wren_cnt), v.is_wr ? 32'd0 : 32'd128);
        chk("stb_hold_viol", 32'(hold_viol), 32'd0);
        chk("xfer_err", 32'(xfer_err), 32'(v.exp_err));
        repeat (3) @(negedge clk_50);
        if (v.is_wr) begin
            chk("done_held", 32'(ext_write_done), 32'd1);
            ext_write_act = 1'b0;
            @(negedge clk_50);
            chk("done_fall", 32'(ext_write_done), 32'd0);
        end else begin
            chk("go_held", 32'(ext_read_go), 32'd1);
            ext_read_stop = 1'b1;
            @(negedge clk_50);
            chk("go_fall", 32'(ext_read_go), 32'd0);
            ext_read_stop = 1'b0;
            ext_read_act  = 1'b0;
        end
        repeat (2) @(negedge clk_50);
        chk("cyc_idle", 32'(wbm_cyc_o), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        vec_t after_rst;
        int n;
        //        wr    sector         waits err  pattern        first          last           lat  err
        vecs[0] = '{1'b0, 32'd5,        0,   -1, 32'h0000_0000, 32'h1000_0A00, 32'h1000_0BFC, 385, 1'b0};
        vecs[1] = '{1'b1, 32'd0,        0,   -1, 32'hA5A5_0000, 32'h1000_0000, 32'h1000_01FC, 385, 1'b0};
        vecs[2] = '{1'b0, 32'd3,        3,   -1, 32'hC0DE_0000, 32'h1000_0600, 32'h1000_07FC, 769, 1'b0};
        vecs[3] = '{1'b1, 32'd9,        3,   -1, 32'h5A5A_0000, 32'h1000_1200, 32'h1000_13FC, 769, 1'b0};
        vecs[4] = '{1'b0, 32'd7,        0,   10, 32'h7700_0000, 32'h1000_0E00, 32'h1000_0FFC, 385, 1'b1};
        vecs[5] = '{1'b0, 32'h0080_0002,0,   -1, 32'h1234_0000, 32'h1000_0400, 32'h1000_05FC, 385, 1'b0};
        vecs[6] = '{1'b1, 32'd1,        1,  127, 32'h0F0F_0000, 32'h1000_0200, 32'h1000_03FC, 513, 1'b1};
        after_rst = '{1'b0, 32'd6,      0,   -1, 32'h6600_0000, 32'h1000_0C00, 32'h1000_0DFC, 385, 1'b0};

        for (int i = 0; i < 128; i++) begin
            rbram[i] = '0; wbram[i] = '0;
        end

        @(negedge clk_50);
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_go_done_err", {29'd0, ext_read_go, ext_write_done, xfer_err}, 32'd0);
        chk("rst_wren_sel_we", {27'd0, bram_rd_ext_wren, wbm_sel_o}, 32'd0);
        repeat (2) @(negedge clk_50);
        reset_n = 1'b1;
        @(negedge clk_50);

        for (int t = 0; t < 7; t++) do_xfer(vecs[t]);

        // Read and write requested together: read first, then write.
        wait_cfg = 0; err_beat = -1; rd_pat = 32'h0; beat_cnt = 0;
        for (int i = 0; i < 128; i++) wbram[i] = 32'h3300_0000 + 32'(i);
        ext_read_addr = 32'd1; ext_write_addr = 32'd2;
        ext_read_act = 1'b1; ext_write_act = 1'b1;
        n = 0;
        do begin @(negedge clk_50); n++; end while (!ext_read_go && n < 3000);
        chk("both_read_first_adr", adr_log[0], 32'h1000_0200);
        chk("both_read_first_we", 32'(we_log[0]), 32'd0);
        chk("both_read_beats", 32'(beat_cnt), 32'd128);
        chk("both_no_done_yet", 32'(ext_write_done), 32'd0);
        ext_read_stop = 1'b1;
        beat_cnt = 0;
        @(negedge clk_50);
        ext_read_stop = 1'b0; ext_read_act = 1'b0;
        n = 0;
        do begin @(negedge clk_50); n++; end while (!ext_write_done && n < 3000);
        chk("both_write_done", 32'(ext_write_done), 32'd1);
        chk("both_write_first_adr", adr_log[0], 32'h1000_0400);
        chk("both_write_first_we", 32'(we_log[0]), 32'd1);
        chk("both_write_beats", 32'(beat_cnt), 32'd128);
        chk("both_write_dat5", wdat_log[5], sw(32'h3300_0005));
        ext_write_act = 1'b0;
        repeat (3) @(negedge clk_50);

        // Asynchronous reset in the middle of a read sector.
        beat_cnt = 0; ext_read_addr = 32'd4; ext_read_act = 1'b1;
        n = 0;
        do begin @(negedge clk_50); n++; end while (!(beat_cnt == 64 && wbm_stb_o) && n < 3000);
        chk("cyc_before_reset", 32'(wbm_cyc_o), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("reset_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("reset_stb", 32'(wbm_stb_o), 32'd0);
        chk("reset_go", 32'(ext_read_go), 32'd0);
        chk("reset_adr", wbm_adr_o, 32'd0);
        ext_read_act = 1'b0;
        repeat (2) @(negedge clk_50);
        reset_n = 1'b1;
        @(negedge clk_50);
        do_xfer(after_rst);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
